// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control logic.
// State encoding, register constants and the IF/ID flush NOP.
package mips_pipe_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && count != MAX)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl_id_ex.sv
// ID/EX hazard control: load-use stalls and taken-branch flushes.
// Outputs are combinational on the current inputs and FSM state.
module hazard_ctrl_id_ex
  import mips_pipe_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic [4:0]       i_idex_rt,
  input  logic             i_idex_memRead,
  input  logic             i_exmem_branch,
  input  logic             i_exmem_zero,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_idex_bubble,
  output logic             o_ifid_flush,
  output logic             o_exmem_flush,
  output logic             o_pc_src,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam logic [2:0] REM_INIT = 3'(LOAD_STALL - 1);

  hz_state_e  state;
  logic [2:0] rem;
  logic       hz;
  logic       tk;
  logic       stall_cyc;

  assign hz = i_idex_memRead
           && (i_idex_rt != REG_ZERO)
           && (i_idex_rt == i_ifid_rs
            || i_idex_rt == i_ifid_rt);

  assign tk = i_exmem_branch && i_exmem_zero;

  // A taken branch makes the stalled instruction wrong-path.
  assign stall_cyc = !tk && (state == STALL || hz);

  always_comb begin
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_idex_bubble = 1'b0;
    o_ifid_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    o_pc_src      = 1'b0;
    if (reset) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_bubble = 1'b1;
      o_ifid_flush  = 1'b1;
    end else if (tk) begin
      o_pc_src      = 1'b1;
      o_idex_bubble = 1'b1;
      o_ifid_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end else if (stall_cyc) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      rem   <= '0;
    end else if (tk) begin
      state <= RUN;
      rem   <= '0;
    end else if (state == STALL) begin
      rem <= rem - 3'd1;
      if (rem == 3'd1)
        state <= RUN;
    end else if (hz && LOAD_STALL > 1) begin
      state <= STALL;
      rem   <= REM_INIT;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (!reset && stall_cyc),
    .count (o_stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (!reset && tk),
    .count (o_flush_count)
  );

endmodule
